// File: rtl/xor_stream_acc.sv
// Purpose: XOR-accumulates a stream of beats per frame and reports XOR, parity, length, cut flag.
// Latency: result valid the cycle after the frame's final accepting edge.
// Backpressure: IN_READY low while a result is held; result held stable until OUT_READY.
module xor_stream_acc #(
  parameter  int WIDTH      = 8,
  parameter  int MAX_LEN    = 16,
  parameter  int PARITY_ODD = 0,
  localparam int LW         = $clog2(MAX_LEN + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  input  logic             IN_LAST,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_PARITY,
  output logic [LW-1:0]    OUT_LEN,
  output logic             OUT_ERR,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [LW-1:0]    r_len;
  logic             r_err;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_accept;
  logic [WIDTH-1:0] w_next_acc;
  logic [LW-1:0]    w_next_len;
  logic             w_frame_end;

  // Next accumulator/length for a beat; a beat taken in IDLE starts a fresh frame.
  always_comb begin
    w_accept    = IN_VALID & r_in_ready;
    w_next_acc  = (r_state == IDLE) ? IN_DATA : (r_acc ^ IN_DATA);
    w_next_len  = (r_state == IDLE) ? LW'(1) : (r_len + LW'(1));
    w_frame_end = IN_LAST | (w_next_len == LW'(MAX_LEN));
  end

  // Frame FSM: accumulate beats, hold the result until downstream takes it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_len       <= '0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            r_acc <= w_next_acc;
            r_len <= w_next_len;
            if (w_frame_end) begin
              // Cut frames (length reached without IN_LAST) are flagged.
              r_err       <= ~IN_LAST;
              r_state     <= HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (OUT_READY) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY   = r_in_ready;
  assign OUT_VALID  = r_out_valid;
  assign OUT_DATA   = r_acc;
  assign OUT_LEN    = r_len;
  assign OUT_ERR    = r_err;
  assign OUT_PARITY = (^r_acc) ^ 1'(PARITY_ODD);

endmodule

// File: tb/tb_xor_stream_acc.sv
// Bench for xor_stream_acc: random/directed frames against a frame-level reference model.
// Expected results queue at frame end; a negedge monitor compares whenever OUT_VALID is high.
// OUT_READY is randomly throttled, with forced multi-cycle stalls on request.
module tb_xor_stream_acc;

  localparam int WIDTH      = 8;
  localparam int MAX_LEN    = 4;
  localparam int PARITY_ODD = 0;
  localparam int LW         = $clog2(MAX_LEN + 1);

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [WIDTH-1:0] IN_DATA = '0;
  logic             IN_VALID = 1'b0;
  logic             IN_LAST = 1'b0;
  logic             IN_READY;
  logic [WIDTH-1:0] OUT_DATA;
  logic             OUT_PARITY;
  logic [LW-1:0]    OUT_LEN;
  logic             OUT_ERR;
  logic             OUT_VALID;
  logic             OUT_READY = 1'b0;

  xor_stream_acc #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .PARITY_ODD(PARITY_ODD)) dut (
    .CLK(CLK), .RST(RST),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST), .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA), .OUT_PARITY(OUT_PARITY), .OUT_LEN(OUT_LEN), .OUT_ERR(OUT_ERR),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             p;
    logic [LW-1:0]    len;
    logic             err;
  } res_t;

  res_t             exp_q[$];
  logic [WIDTH-1:0] cur_q[$];
  int checks   = 0;
  int failures = 0;
  bit valid_due = 0;
  bit hs_prev = 0;
  bit stall_req = 0;
  int stall_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collect beats, produce the result when the frame closes.
  task automatic model_beat(input logic [WIDTH-1:0] d, input logic last);
    res_t r;
    cur_q.push_back(d);
    if (last || cur_q.size() == MAX_LEN) begin
      r.d = '0;
      foreach (cur_q[i]) r.d = r.d ^ cur_q[i];
      r.len = LW'(cur_q.size());
      r.err = !last;
      r.p   = 1'(($countones(r.d) % 2) ^ PARITY_ODD);
      exp_q.push_back(r);
      cur_q.delete();
      valid_due = 1;
      if (stall_req) begin
        stall_cycles = 10;
        stall_req = 0;
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input logic [WIDTH-1:0] d, input logic last);
    int n;
    IN_VALID = 1'b1; IN_DATA = d; IN_LAST = last;
    n = 0;
    forever begin
      @(negedge CLK);
      if (IN_READY) break;
      n++;
      if (n > 200) begin
        chk("in_ready_timeout", 32'(IN_READY), 32'd1);
        IN_VALID = 1'b0;
        return;
      end
    end
    @(posedge CLK);
    model_beat(d, last);
    #1;
    IN_VALID = 1'b0;
    IN_DATA  = WIDTH'($urandom);
    IN_LAST  = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      IN_DATA = WIDTH'($urandom);
      IN_LAST = 1'($urandom);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; IN_VALID = 1'b0;
    exp_q.delete(); cur_q.delete();
    valid_due = 0; hs_prev = 0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_out_data", 32'(OUT_DATA), 32'd0);
    chk("rst_out_len", 32'(OUT_LEN), 32'd0);
    chk("rst_out_err", 32'(OUT_ERR), 32'd0);
    chk("rst_out_parity", 32'(OUT_PARITY), 32'(PARITY_ODD));
    chk("rst_in_ready", 32'(IN_READY), 32'd1);
    @(posedge CLK);
    #1;
  endtask

  // Downstream readiness: random throttling, or a forced stall run.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (stall_cycles > 0) begin
        OUT_READY = 1'b0;
        stall_cycles--;
      end else begin
        OUT_READY = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: compare held result against the queue head every valid cycle.
  always @(negedge CLK) begin
    if (!RST) begin
      if (valid_due) begin
        chk("latency_out_valid", 32'(OUT_VALID), 32'd1);
        valid_due = 0;
      end
      if (hs_prev) begin
        chk("post_handshake_valid", 32'(OUT_VALID), 32'd0);
        hs_prev = 0;
      end
      if (OUT_VALID) begin
        chk("hold_in_ready", 32'(IN_READY), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(OUT_VALID), 32'd0);
        end else begin
          chk("out_data", 32'(OUT_DATA), 32'(exp_q[0].d));
          chk("out_len", 32'(OUT_LEN), 32'(exp_q[0].len));
          chk("out_err", 32'(OUT_ERR), 32'(exp_q[0].err));
          chk("out_parity", 32'(OUT_PARITY), 32'(exp_q[0].p));
          if (OUT_READY) begin
            void'(exp_q.pop_front());
            hs_prev = 1;
          end
        end
      end
    end
  end

  initial begin
    int n;
    int len;
    #1;
    do_reset();

    // Three-beat frame: 0F ^ F0 ^ 3C = C3.
    send_beat(8'h0F, 1'b0);
    send_beat(8'hF0, 1'b0);
    send_beat(8'h3C, 1'b1);
    idle(3);

    // Single-beat frame.
    send_beat(8'h01, 1'b1);
    idle(3);

    // Five beats without LAST: cut at 4, fifth starts a new frame.
    for (int i = 0; i < 5; i++) send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b1);
    idle(3);

    // LAST on the MAX_LEN-th beat is not an error.
    for (int i = 0; i < 4; i++) send_beat(8'(8'h10 + i), i == 3);
    idle(3);

    // Forced 10-cycle downstream stall with input pressure behind it.
    stall_req = 1;
    send_beat(8'h5A, 1'b0);
    send_beat(8'h77, 1'b1);
    send_beat(8'h42, 1'b1);
    idle(3);

    // Reset mid-frame discards the partial frame.
    send_beat(8'hAA, 1'b0);
    send_beat(8'h55, 1'b0);
    do_reset();
    send_beat(8'h11, 1'b1);
    idle(3);

    // IN_VALID gaps inside a frame with garbage on the data/last lines.
    send_beat(8'h81, 1'b0);
    idle(4);
    send_beat(8'h18, 1'b0);
    idle(2);
    send_beat(8'h66, 1'b1);
    idle(3);

    // Random frames with random gaps, lengths crossing MAX_LEN, occasional reset.
    for (int f = 0; f < 60; f++) begin
      len = $urandom_range(1, MAX_LEN + 2);
      for (int b = 0; b < len; b++) begin
        send_beat(WIDTH'($urandom), (b == len - 1) && ($urandom_range(0, 3) != 0));
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      if (f == 30) begin
        send_beat(WIDTH'($urandom), 1'b0);
        do_reset();
      end
      if ($urandom_range(0, 9) == 0) stall_req = 1;
    end

    // Flush: close any open frame and drain outstanding results.
    send_beat(8'hC7, 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge CLK);
      n++;
    end
    idle(2);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/xor_stream_acc.md
XOR_STREAM_ACC -- requirements
Module: xor_stream_acc

Interface
REQ-001 SHALL have parameter WIDTH, 8, bit width of data words (>=1).
REQ-002 SHALL have parameter MAX_LEN, 16, maximum beats per frame (>=1).
REQ-003 SHALL have parameter PARITY_ODD, 0, parity sense: 0 = even, 1 = odd.
REQ-004 SHALL use LW = $clog2(MAX_LEN+1) as the width of the length counter and of OUT_LEN.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port CLK  input  1  clock; all state changes on rising edge.
REQ-007 SHALL have port RST  input  1  synchronous active-high reset.
REQ-008 SHALL have port IN_DATA  input  WIDTH  input word.
REQ-009 SHALL have port IN_VALID  input  1  IN_DATA/IN_LAST valid.
REQ-010 SHALL have port IN_LAST  input  1  marks final beat of frame.
REQ-011 SHALL have port IN_READY  output  1  block accepts a beat this cycle.
REQ-012 SHALL have port OUT_DATA  output  WIDTH  XOR of all frame beats.
REQ-013 SHALL have port OUT_PARITY  output  1  parity of OUT_DATA per PARITY_ODD.
REQ-014 SHALL have port OUT_LEN  output  LW  beats accepted in frame.
REQ-015 SHALL have port OUT_ERR  output  1  frame cut at MAX_LEN without IN_LAST.
REQ-016 SHALL have port OUT_VALID  output  1  result fields valid.
REQ-017 SHALL have port OUT_READY  input  1  downstream accepts result.

Function
REQ-018 SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-019 SHALL accept a beat only when IN_VALID=1 and IN_READY=1 at a rising edge.
REQ-020 SHALL drive IN_READY=1 in IDLE and ACCUM, and 0 in HOLD (one-bubble turnaround).
REQ-021 SHALL, on a beat accepted in IDLE, load acc=IN_DATA and len=1, then go to ACCUM (or directly to HOLD if the frame ends on that beat, per REQ-023).
REQ-022 SHALL, on a beat accepted in ACCUM, set acc=acc^IN_DATA and len=len+1.
REQ-023 SHALL end the frame on the accepted beat when IN_LAST=1 or the new len equals MAX_LEN; on frame end go to HOLD.
REQ-024 SHALL, in HOLD, drive OUT_VALID=1 with OUT_DATA=acc, OUT_LEN=len, OUT_PARITY=(^acc)^PARITY_ODD, OUT_ERR=1 iff the frame ended by length with IN_LAST=0.
REQ-025 SHALL set OUT_ERR=0 when IN_LAST=1 on the MAX_LEN-th beat.
REQ-026 SHALL assert OUT_VALID on the first cycle after the final beat's accepting edge (latency 1).
REQ-027 SHALL hold all OUT_* stable while OUT_VALID=1 and OUT_READY=0.
REQ-028 SHALL, on the edge with OUT_VALID=1 and OUT_READY=1, return to IDLE and deassert OUT_VALID next cycle.
REQ-029 SHALL leave acc and len unchanged on cycles with no accepted beat (IN_VALID gaps permitted mid-frame).
REQ-030 SHALL treat beats following a length-cut frame as the start of a new frame.
REQ-031 SHALL ignore IN_DATA/IN_LAST whenever no beat is accepted.

Reset
REQ-032 SHALL, when RST=1 at a rising edge, enter IDLE and clear acc, len, and the error flag, overriding every other event on that edge, including mid-frame and in HOLD.
REQ-033 SHALL present, in the cycle after reset, OUT_VALID=0, OUT_DATA=0, OUT_LEN=0, OUT_ERR=0, OUT_PARITY=PARITY_ODD, IN_READY=1.
REQ-034 SHALL discard any partial frame or undelivered result on reset.

Verification (WIDTH=8, MAX_LEN=4, PARITY_ODD=0 unless stated)
REQ-035 SHALL cover: RST high 2 cycles -> OUT_VALID=0, OUT_DATA=0x00, OUT_LEN=0, OUT_ERR=0, OUT_PARITY=0, IN_READY=1.
REQ-036 SHALL cover: beats 0x0F, 0xF0, 0x3C (LAST on third), OUT_READY=1 -> next cycle OUT_VALID=1, OUT_DATA=0xC3, OUT_LEN=3, OUT_PARITY=0, OUT_ERR=0; OUT_VALID=0 the following cycle.
REQ-037 SHALL cover: single beat 0x01 with LAST -> OUT_DATA=0x01, OUT_LEN=1, OUT_PARITY=1 (PARITY_ODD=1 build: 0).
REQ-038 SHALL cover: five beats of 0x01 with no LAST -> after 4th: OUT_DATA=0x00, OUT_LEN=4, OUT_ERR=1, IN_READY=0; after drain, the 5th beat starts a new frame, OUT_LEN=1 at its frame end.
REQ-039 SHALL cover: OUT_READY=0 for 10 cycles after frame end -> OUT_* constant, IN_READY=0, IN_VALID stalled; OUT_READY=1 -> single handshake, return to IDLE.
REQ-040 SHALL cover: beats 0xAA, 0x55 then RST mid-frame, then beat 0x11 with LAST -> OUT_DATA=0x11, OUT_LEN=1; IN_VALID gaps inside a frame do not change the result.
